// File: rtl/weight_shift_array_pkg.sv
// Shared types and default sizing for the weight shift array.
// The FSM state type and the default parameter values live here.
package weight_shift_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_CH = 16;
  localparam int DEF_DW = 8;
  localparam int DEF_K  = 3;
  localparam int DEF_OW = 19;
  localparam int DEF_AW = 4;

endpackage

// File: rtl/weight_shift_array_wrap_counter.sv
// Modulo-(MAX+1) counter with a combinational wrap flag.
// Wrap flags are chained between counters to form a mixed-radix counter.
module wrap_counter
  import weight_shift_array_pkg::*;
#(
  parameter int MAX = 2,
  parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    wrap = en && (q_q == W'(MAX));
    q_d  = q_q;
    if (wrap) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/weight_shift_array.sv
// Loads a KxK grid of per-channel weights from memory, then rotates it one
// kernel position per step while sweeping kernel and output-map counters.
module weight_shift_array
  import weight_shift_array_pkg::*;
#(
  parameter int CH = DEF_CH,
  parameter int DW = DEF_DW,
  parameter int K  = DEF_K,
  parameter int OW = DEF_OW,
  parameter int AW = DEF_AW
) (
  input  logic                    clk,
  input  logic                    xrst,
  input  logic                    start,
  input  logic                    step,
  output logic                    ren,
  output logic [AW-1:0]           raddr,
  input  logic [CH*DW-1:0]        rdata,
  output logic [K*K*CH*DW-1:0]    w_out,
  output logic [$clog2(K)-1:0]    x,
  output logic [$clog2(K)-1:0]    y,
  output logic [$clog2(OW)-1:0]   X,
  output logic [$clog2(OW)-1:0]   Y,
  output logic                    busy,
  output logic                    finish
);

  localparam int NS  = K * K;
  localparam int SW  = CH * DW;
  localparam int LCW = $clog2(NS + 1);

  state_t          state_q, state_d;
  logic [LCW-1:0]  load_cnt_q, load_cnt_d;
  logic            ren_q, ren_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            prev_ren_q;
  logic [AW-1:0]   prev_raddr_q;
  logic            busy_q, busy_d;
  logic            finish_q, finish_d;

  logic [SW-1:0]   slot_q [NS];
  logic [SW-1:0]   slot_d [NS];
  logic [SW-1:0]   rot_h  [NS];
  logic [SW-1:0]   rot_hv [NS];

  logic            run_step;
  logic            kx_wrap, ky_wrap, ox_wrap, oy_wrap;

  assign run_step = (state_q == ST_RUN) && step;

  // Counters are always zero in IDLE (after reset, or after the final step
  // wraps them all), so entering LOAD needs no separate clear.
  wrap_counter #(.MAX(K - 1)) u_kx (
    .clk  (clk),
    .xrst (xrst),
    .en   (run_step),
    .q    (x),
    .wrap (kx_wrap)
  );

  wrap_counter #(.MAX(K - 1)) u_ky (
    .clk  (clk),
    .xrst (xrst),
    .en   (kx_wrap),
    .q    (y),
    .wrap (ky_wrap)
  );

  wrap_counter #(.MAX(OW - 1)) u_ox (
    .clk  (clk),
    .xrst (xrst),
    .en   (ky_wrap),
    .q    (X),
    .wrap (ox_wrap)
  );

  wrap_counter #(.MAX(OW - 1)) u_oy (
    .clk  (clk),
    .xrst (xrst),
    .en   (ox_wrap),
    .q    (Y),
    .wrap (oy_wrap)
  );

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    ren_d      = 1'b0;
    raddr_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
          ren_d      = 1'b1;
          raddr_d    = '0;
        end
      end
      ST_LOAD: begin
        load_cnt_d = load_cnt_q + LCW'(1);
        // One extra cycle after the last read so its data can land.
        if (load_cnt_q == LCW'(NS)) begin
          state_d = ST_RUN;
        end else if (load_cnt_q < LCW'(NS - 1)) begin
          ren_d   = 1'b1;
          raddr_d = AW'(load_cnt_q + LCW'(1));
        end
      end
      ST_RUN: begin
        if (oy_wrap) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_RUN);
    finish_d = (state_d == ST_DONE);
  end

  // Precomputed rotations: horizontal only, and horizontal plus vertical.
  genvar gi, gj;
  generate
    for (gi = 0; gi < K; gi++) begin : g_row
      for (gj = 0; gj < K; gj++) begin : g_col
        assign rot_h[gi*K + gj]  = slot_q[gi*K + ((gj + 1) % K)];
        assign rot_hv[gi*K + gj] = slot_q[((gi + 1) % K)*K + ((gj + 1) % K)];
      end
    end
  endgenerate

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      slot_d[s] = slot_q[s];
    end
    if (run_step) begin
      for (int s = 0; s < NS; s++) begin
        slot_d[s] = kx_wrap ? rot_hv[s] : rot_h[s];
      end
    end else if ((state_q == ST_LOAD) && prev_ren_q) begin
      for (int s = 0; s < NS; s++) begin
        if (prev_raddr_q == AW'(s)) begin
          slot_d[s] = rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= ST_IDLE;
      load_cnt_q   <= '0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      prev_ren_q   <= 1'b0;
      prev_raddr_q <= '0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      for (int s = 0; s < NS; s++) begin
        slot_q[s] <= '0;
      end
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      ren_q        <= ren_d;
      raddr_q      <= raddr_d;
      prev_ren_q   <= ren_q;
      prev_raddr_q <= raddr_q;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
      for (int s = 0; s < NS; s++) begin
        slot_q[s] <= slot_d[s];
      end
    end
  end

  generate
    for (gi = 0; gi < NS; gi++) begin : g_wout
      assign w_out[gi*SW +: SW] = slot_q[gi];
    end
  endgenerate

  assign ren    = ren_q;
  assign raddr  = raddr_q;
  assign busy   = busy_q;
  assign finish = finish_q;

endmodule
